// File: rtl/axi2lite_pkg.sv
// Shared encodings, FSM state types and the response merge
// helper used by the AXI4-to-AXI-Lite burst bridge.
package axi2lite_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_BEAT,
    W_RESP,
    W_BRESP
  } wr_state_e;

  // Severity order: DECERR > SLVERR > OKAY. EXOKAY ranks as OKAY
  // so an accumulator seeded with OKAY never reports EXOKAY.
  function automatic logic [1:0] resp_rank(
    input logic [1:0] r
  );
    logic [1:0] k;
    k = 2'd0;
    unique case (1'b1)
      (r == RESP_DECERR): k = 2'd2;
      (r == RESP_SLVERR): k = 2'd1;
      default:            k = 2'd0;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] resp_merge(
    input logic [1:0] acc,
    input logic [1:0] resp
  );
    return (resp_rank(resp) > resp_rank(acc)) ? resp : acc;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for AXI4 FIXED/INCR/WRAP bursts.
// Ports: addr/len/size/burst of the current beat -> next_addr.
module axi_burst_addr_gen
  import axi2lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit WRAP_EN    = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] beats;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign bytes     = ADDR_WIDTH'(1) << size;
  // Later beats are size-aligned even if the first was not.
  assign aligned   = addr & ~(bytes - ADDR_WIDTH'(1));
  assign incr      = aligned + bytes;
  assign beats     = ADDR_WIDTH'(len) + ADDR_WIDTH'(1);
  assign wrap_mask = (beats << size) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr = incr;
    unique case (1'b1)
      (burst == BURST_FIXED):
        next_addr = addr;
      (burst == BURST_WRAP && WRAP_EN):
        next_addr = (addr & ~wrap_mask)
                  | (incr & wrap_mask);
      default:
        next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_to_axi_lite_burst.sv
// AXI4 slave to AXI-Lite master bridge: splits bursts into single
// Lite beats, reflects IDs, builds r_last, merges B per burst.
// Ports: aclk, areset (sync, high), slv_* AXI4 slave, mst_* Lite master.
module axi_to_axi_lite_burst
  import axi2lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter bit WRAP_EN    = 1'b1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     slv_aw_id,
  input  logic [ADDR_WIDTH-1:0]   slv_aw_addr,
  input  logic [7:0]              slv_aw_len,
  input  logic [2:0]              slv_aw_size,
  input  logic [1:0]              slv_aw_burst,
  input  logic                    slv_aw_lock,
  input  logic [2:0]              slv_aw_prot,
  input  logic                    slv_aw_valid,
  output logic                    slv_aw_ready,
  input  logic [DATA_WIDTH-1:0]   slv_w_data,
  input  logic [DATA_WIDTH/8-1:0] slv_w_strb,
  input  logic                    slv_w_last,
  input  logic                    slv_w_valid,
  output logic                    slv_w_ready,
  output logic [ID_WIDTH-1:0]     slv_b_id,
  output logic [1:0]              slv_b_resp,
  output logic                    slv_b_valid,
  input  logic                    slv_b_ready,
  input  logic [ID_WIDTH-1:0]     slv_ar_id,
  input  logic [ADDR_WIDTH-1:0]   slv_ar_addr,
  input  logic [7:0]              slv_ar_len,
  input  logic [2:0]              slv_ar_size,
  input  logic [1:0]              slv_ar_burst,
  input  logic                    slv_ar_lock,
  input  logic [2:0]              slv_ar_prot,
  input  logic                    slv_ar_valid,
  output logic                    slv_ar_ready,
  output logic [ID_WIDTH-1:0]     slv_r_id,
  output logic [DATA_WIDTH-1:0]   slv_r_data,
  output logic [1:0]              slv_r_resp,
  output logic                    slv_r_last,
  output logic                    slv_r_valid,
  input  logic                    slv_r_ready,
  output logic [ADDR_WIDTH-1:0]   mst_aw_addr,
  output logic [2:0]              mst_aw_prot,
  output logic                    mst_aw_valid,
  input  logic                    mst_aw_ready,
  output logic [DATA_WIDTH-1:0]   mst_w_data,
  output logic [DATA_WIDTH/8-1:0] mst_w_strb,
  output logic                    mst_w_valid,
  input  logic                    mst_w_ready,
  input  logic [1:0]              mst_b_resp,
  input  logic                    mst_b_valid,
  output logic                    mst_b_ready,
  output logic [ADDR_WIDTH-1:0]   mst_ar_addr,
  output logic [2:0]              mst_ar_prot,
  output logic                    mst_ar_valid,
  input  logic                    mst_ar_ready,
  input  logic [DATA_WIDTH-1:0]   mst_r_data,
  input  logic [1:0]              mst_r_resp,
  input  logic                    mst_r_valid,
  output logic                    mst_r_ready
);

  // Lock is forwarded as a plain access; w_last is not trusted.
  logic unused_ok;
  assign unused_ok = ^{slv_w_last, slv_aw_lock, slv_ar_lock};

  // ---------------- read path ----------------
  rd_state_e             rd_state, rd_next;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
  logic [7:0]            rd_len, rd_cnt;
  logic [2:0]            rd_size, rd_prot;
  logic [1:0]            rd_burst;
  logic                  rd_last;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WRAP_EN   (WRAP_EN)
  ) u_rd_ag (
    .addr     (rd_addr),
    .len      (rd_len),
    .size     (rd_size),
    .burst    (rd_burst),
    .next_addr(rd_addr_nxt)
  );

  assign rd_last     = (rd_cnt == rd_len);
  assign mst_ar_addr = rd_addr;
  assign mst_ar_prot = rd_prot;
  assign slv_r_id    = rd_id;
  assign slv_r_data  = mst_r_data;
  assign slv_r_resp  = mst_r_resp;
  assign slv_r_last  = rd_last;

  always_comb begin
    rd_next      = rd_state;
    slv_ar_ready = 1'b0;
    mst_ar_valid = 1'b0;
    mst_r_ready  = 1'b0;
    slv_r_valid  = 1'b0;
    if (!areset) begin
      unique case (rd_state)
        R_IDLE: begin
          slv_ar_ready = 1'b1;
          if (slv_ar_valid) rd_next = R_ADDR;
        end
        R_ADDR: begin
          mst_ar_valid = 1'b1;
          if (mst_ar_ready) rd_next = R_DATA;
        end
        R_DATA: begin
          mst_r_ready = slv_r_ready;
          slv_r_valid = mst_r_valid;
          if (mst_r_valid && slv_r_ready)
            rd_next = rd_last ? R_IDLE : R_ADDR;
        end
        default: rd_next = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state <= R_IDLE;
      rd_id    <= '0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      rd_prot  <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_state == R_IDLE && slv_ar_valid) begin
        rd_id    <= slv_ar_id;
        rd_addr  <= slv_ar_addr;
        rd_len   <= slv_ar_len;
        rd_size  <= slv_ar_size;
        rd_burst <= slv_ar_burst;
        rd_prot  <= slv_ar_prot;
        rd_cnt   <= '0;
      end
      if (rd_state == R_DATA && mst_r_valid
          && slv_r_ready && !rd_last) begin
        rd_cnt  <= rd_cnt + 8'd1;
        rd_addr <= rd_addr_nxt;
      end
    end
  end

  // ---------------- write path ----------------
  wr_state_e             wr_state, wr_next;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
  logic [7:0]            wr_len, wr_cnt;
  logic [2:0]            wr_size, wr_prot;
  logic [1:0]            wr_burst, wr_acc;
  logic                  aw_done, w_done;
  logic                  aw_hs, w_hs;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WRAP_EN   (WRAP_EN)
  ) u_wr_ag (
    .addr     (wr_addr),
    .len      (wr_len),
    .size     (wr_size),
    .burst    (wr_burst),
    .next_addr(wr_addr_nxt)
  );

  assign mst_aw_addr = wr_addr;
  assign mst_aw_prot = wr_prot;
  assign mst_w_data  = slv_w_data;
  assign mst_w_strb  = slv_w_strb;
  assign slv_b_id    = wr_id;
  assign slv_b_resp  = wr_acc;
  assign aw_hs       = mst_aw_valid && mst_aw_ready;
  assign w_hs        = mst_w_valid && mst_w_ready;

  always_comb begin
    wr_next      = wr_state;
    slv_aw_ready = 1'b0;
    mst_aw_valid = 1'b0;
    mst_w_valid  = 1'b0;
    slv_w_ready  = 1'b0;
    mst_b_ready  = 1'b0;
    slv_b_valid  = 1'b0;
    if (!areset) begin
      unique case (wr_state)
        W_IDLE: begin
          slv_aw_ready = 1'b1;
          if (slv_aw_valid) wr_next = W_BEAT;
        end
        W_BEAT: begin
          // AW and W finish independently; each drops after its
          // own handshake and both must be done to move on.
          mst_aw_valid = !aw_done;
          mst_w_valid  = slv_w_valid && !w_done;
          slv_w_ready  = mst_w_ready && !w_done;
          if ((aw_done || mst_aw_ready)
              && (w_done || (slv_w_valid && mst_w_ready)))
            wr_next = W_RESP;
        end
        W_RESP: begin
          mst_b_ready = 1'b1;
          if (mst_b_valid)
            wr_next = (wr_cnt == wr_len) ? W_BRESP : W_BEAT;
        end
        W_BRESP: begin
          slv_b_valid = 1'b1;
          if (slv_b_ready) wr_next = W_IDLE;
        end
        default: wr_next = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state <= W_IDLE;
      wr_id    <= '0;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_cnt   <= '0;
      wr_size  <= '0;
      wr_burst <= '0;
      wr_prot  <= '0;
      wr_acc   <= RESP_OKAY;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (wr_state == W_IDLE && slv_aw_valid) begin
        wr_id    <= slv_aw_id;
        wr_addr  <= slv_aw_addr;
        wr_len   <= slv_aw_len;
        wr_size  <= slv_aw_size;
        wr_burst <= slv_aw_burst;
        wr_prot  <= slv_aw_prot;
        wr_cnt   <= '0;
        wr_acc   <= RESP_OKAY;
      end
      if (wr_state != W_BEAT) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (wr_state == W_RESP && mst_b_valid) begin
        wr_acc <= resp_merge(wr_acc, mst_b_resp);
        if (wr_cnt != wr_len) begin
          wr_cnt  <= wr_cnt + 8'd1;
          wr_addr <= wr_addr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_to_axi_lite_burst.sv
// Directed bench for axi_to_axi_lite_burst with a responsive
// AXI-Lite slave model and hand-computed expected values.
module tb_axi_to_axi_lite_burst;
  import axi2lite_pkg::*;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  slv_aw_id, slv_ar_id, slv_b_id, slv_r_id;
  logic [31:0] slv_aw_addr, slv_ar_addr;
  logic [7:0]  slv_aw_len, slv_ar_len;
  logic [2:0]  slv_aw_size, slv_ar_size;
  logic [1:0]  slv_aw_burst, slv_ar_burst;
  logic        slv_aw_lock, slv_ar_lock;
  logic [2:0]  slv_aw_prot, slv_ar_prot;
  logic        slv_aw_valid, slv_aw_ready;
  logic [31:0] slv_w_data, slv_r_data;
  logic [3:0]  slv_w_strb;
  logic        slv_w_last, slv_w_valid, slv_w_ready;
  logic [1:0]  slv_b_resp, slv_r_resp;
  logic        slv_b_valid, slv_b_ready;
  logic        slv_ar_valid, slv_ar_ready;
  logic        slv_r_last, slv_r_valid, slv_r_ready;
  logic [31:0] mst_aw_addr, mst_ar_addr;
  logic [2:0]  mst_aw_prot, mst_ar_prot;
  logic        mst_aw_valid, mst_aw_ready;
  logic [31:0] mst_w_data, mst_r_data;
  logic [3:0]  mst_w_strb;
  logic        mst_w_valid, mst_w_ready;
  logic [1:0]  mst_b_resp, mst_r_resp;
  logic        mst_b_valid, mst_b_ready;
  logic        mst_ar_valid, mst_ar_ready;
  logic        mst_r_valid, mst_r_ready;

  always #5 clk = ~clk;

  axi_to_axi_lite_burst dut (
    .aclk(clk), .areset(areset),
    .slv_aw_id(slv_aw_id), .slv_aw_addr(slv_aw_addr),
    .slv_aw_len(slv_aw_len), .slv_aw_size(slv_aw_size),
    .slv_aw_burst(slv_aw_burst), .slv_aw_lock(slv_aw_lock),
    .slv_aw_prot(slv_aw_prot), .slv_aw_valid(slv_aw_valid),
    .slv_aw_ready(slv_aw_ready),
    .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb),
    .slv_w_last(slv_w_last), .slv_w_valid(slv_w_valid),
    .slv_w_ready(slv_w_ready),
    .slv_b_id(slv_b_id), .slv_b_resp(slv_b_resp),
    .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
    .slv_ar_id(slv_ar_id), .slv_ar_addr(slv_ar_addr),
    .slv_ar_len(slv_ar_len), .slv_ar_size(slv_ar_size),
    .slv_ar_burst(slv_ar_burst), .slv_ar_lock(slv_ar_lock),
    .slv_ar_prot(slv_ar_prot), .slv_ar_valid(slv_ar_valid),
    .slv_ar_ready(slv_ar_ready),
    .slv_r_id(slv_r_id), .slv_r_data(slv_r_data),
    .slv_r_resp(slv_r_resp), .slv_r_last(slv_r_last),
    .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
    .mst_aw_addr(mst_aw_addr), .mst_aw_prot(mst_aw_prot),
    .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
    .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb),
    .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
    .mst_b_resp(mst_b_resp), .mst_b_valid(mst_b_valid),
    .mst_b_ready(mst_b_ready),
    .mst_ar_addr(mst_ar_addr), .mst_ar_prot(mst_ar_prot),
    .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
    .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp),
    .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  // Lite slave model state
  logic [31:0] rd_log[$];
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  int          wb_idx;
  int          err_beat;
  logic [1:0]  err_resp;
  logic        b_hold;
  logic        got_aw, got_w;

  function automatic logic [31:0] rmem(input logic [31:0] a);
    return (a == 32'h1000_0004) ? 32'hDEAD_BEEF
                                : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Read side: AR always ready, R one cycle after AR.
  initial begin
    logic ar_hs, r_hs, rst;
    logic [31:0] a;
    mst_ar_ready = 1'b1;
    mst_r_valid  = 1'b0;
    mst_r_data   = '0;
    mst_r_resp   = RESP_OKAY;
    forever begin
      @(negedge clk);
      ar_hs = mst_ar_valid && mst_ar_ready;
      r_hs  = mst_r_valid && mst_r_ready;
      a     = mst_ar_addr;
      rst   = areset;
      @(posedge clk); #1;
      if (rst) mst_r_valid = 1'b0;
      else begin
        if (r_hs) mst_r_valid = 1'b0;
        if (ar_hs) begin
          rd_log.push_back(a);
          mst_r_valid = 1'b1;
          mst_r_data  = rmem(a);
          mst_r_resp  = RESP_OKAY;
        end
      end
    end
  end

  // Write side: B once both AW and W of a beat arrived.
  initial begin
    logic aw_hs, w_hs, b_hs, rst;
    logic [31:0] a, d;
    mst_aw_ready = 1'b1;
    mst_w_ready  = 1'b1;
    mst_b_valid  = 1'b0;
    mst_b_resp   = RESP_OKAY;
    got_aw = 1'b0;
    got_w  = 1'b0;
    forever begin
      @(negedge clk);
      aw_hs = mst_aw_valid && mst_aw_ready;
      w_hs  = mst_w_valid && mst_w_ready;
      b_hs  = mst_b_valid && mst_b_ready;
      a     = mst_aw_addr;
      d     = mst_w_data;
      rst   = areset;
      @(posedge clk); #1;
      if (rst) begin
        mst_b_valid = 1'b0;
        got_aw = 1'b0;
        got_w  = 1'b0;
      end else begin
        if (b_hs) mst_b_valid = 1'b0;
        if (aw_hs) begin aw_log.push_back(a); got_aw = 1'b1; end
        if (w_hs)  begin w_log.push_back(d);  got_w  = 1'b1; end
        if (got_aw && got_w && !mst_b_valid && !b_hold) begin
          mst_b_valid = 1'b1;
          mst_b_resp  = (wb_idx == err_beat) ? err_resp
                                             : RESP_OKAY;
          wb_idx++;
          got_aw = 1'b0;
          got_w  = 1'b0;
        end
      end
    end
  end

  task automatic do_read(
    input string tag, input logic [3:0] id,
    input logic [31:0] addr, input logic [7:0] len,
    input logic [1:0] burst,
    input logic [31:0] e0, input logic [31:0] e1,
    input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ea[4];
    int t;
    ea = '{e0, e1, e2, e3};
    rd_log.delete();
    slv_ar_id = id; slv_ar_addr = addr; slv_ar_len = len;
    slv_ar_size = 3'd2; slv_ar_burst = burst;
    slv_ar_prot = 3'b010; slv_ar_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!slv_ar_ready && t < 50);
    if (!slv_ar_ready) chk({tag, "_ar_timeout"}, slv_ar_ready, 1);
    @(posedge clk); #1;
    slv_ar_valid = 1'b0;
    slv_r_ready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      do begin @(negedge clk); t++; end
      while (!slv_r_valid && t < 50);
      if (!slv_r_valid) begin
        chk({tag, "_r_timeout"}, slv_r_valid, 1);
        break;
      end
      chk($sformatf("%s_data%0d", tag, i), slv_r_data, rmem(ea[i]));
      chk($sformatf("%s_last%0d", tag, i), slv_r_last, i == int'(len));
      chk($sformatf("%s_id%0d", tag, i), slv_r_id, id);
      @(posedge clk); #1;
    end
    slv_r_ready = 1'b0;
    chk({tag, "_nbeats"}, rd_log.size(), int'(len) + 1);
    for (int i = 0; i < rd_log.size() && i < 4; i++)
      chk($sformatf("%s_araddr%0d", tag, i), rd_log[i], ea[i]);
  endtask

  task automatic do_write(
    input string tag, input logic [3:0] id,
    input logic [31:0] addr, input logic [7:0] len,
    input logic [1:0] burst, input logic [31:0] dbase,
    input logic [1:0] exp_resp,
    input logic [31:0] e0, input logic [31:0] e1,
    input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ea[4];
    int t;
    ea = '{e0, e1, e2, e3};
    aw_log.delete();
    w_log.delete();
    wb_idx = 0;
    slv_aw_id = id; slv_aw_addr = addr; slv_aw_len = len;
    slv_aw_size = 3'd2; slv_aw_burst = burst;
    slv_aw_prot = 3'b001; slv_aw_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!slv_aw_ready && t < 50);
    if (!slv_aw_ready) chk({tag, "_aw_timeout"}, slv_aw_ready, 1);
    @(posedge clk); #1;
    slv_aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      slv_w_valid = 1'b1;
      slv_w_data  = dbase + 32'(i);
      slv_w_strb  = 4'hF;
      slv_w_last  = (i == int'(len));
      t = 0;
      do begin @(negedge clk); t++; end
      while (!slv_w_ready && t < 50);
      if (!slv_w_ready) begin
        chk($sformatf("%s_w_timeout%0d", tag, i), slv_w_ready, 1);
        break;
      end
      @(posedge clk); #1;
    end
    slv_w_valid = 1'b0;
    slv_w_last  = 1'b0;
    slv_b_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!slv_b_valid && t < 100);
    chk({tag, "_bvalid"}, slv_b_valid, 1);
    chk({tag, "_bresp"}, slv_b_resp, exp_resp);
    chk({tag, "_bid"}, slv_b_id, id);
    @(posedge clk); #1;
    slv_b_ready = 1'b0;
    chk({tag, "_nbeats"}, aw_log.size(), int'(len) + 1);
    for (int i = 0; i < aw_log.size() && i < 4; i++)
      chk($sformatf("%s_awaddr%0d", tag, i), aw_log[i], ea[i]);
    for (int i = 0; i < w_log.size() && i < 4; i++)
      chk($sformatf("%s_wdata%0d", tag, i), w_log[i],
          dbase + 32'(i));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_b;
    int t;
    areset = 1'b1;
    slv_aw_id = '0; slv_aw_addr = '0; slv_aw_len = '0;
    slv_aw_size = '0; slv_aw_burst = '0; slv_aw_lock = 1'b0;
    slv_aw_prot = '0; slv_aw_valid = 1'b0;
    slv_w_data = '0; slv_w_strb = '0; slv_w_last = 1'b0;
    slv_w_valid = 1'b0; slv_b_ready = 1'b0;
    slv_ar_id = '0; slv_ar_addr = '0; slv_ar_len = '0;
    slv_ar_size = '0; slv_ar_burst = '0; slv_ar_lock = 1'b0;
    slv_ar_prot = '0; slv_ar_valid = 1'b0; slv_r_ready = 1'b0;
    err_beat = -1; err_resp = RESP_OKAY; b_hold = 1'b0;
    wb_idx = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_slv_ready", {slv_aw_ready, slv_ar_ready,
        slv_w_ready}, 0);
    chk("rst_slv_valid", {slv_b_valid, slv_r_valid}, 0);
    chk("rst_mst_valid", {mst_aw_valid, mst_ar_valid,
        mst_w_valid}, 0);
    chk("rst_mst_ready", {mst_b_ready, mst_r_ready}, 0);
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    chk("idle_aw_ready", slv_aw_ready, 1);
    chk("idle_ar_ready", slv_ar_ready, 1);
    @(posedge clk); #1;

    do_read("rd_single", 4'd3, 32'h1000_0004, 8'd0, BURST_INCR,
            32'h1000_0004, 0, 0, 0);

    do_read("rd_incr", 4'd5, 32'h2000_0000, 8'd3, BURST_INCR,
            32'h2000_0000, 32'h2000_0004,
            32'h2000_0008, 32'h2000_000C);

    do_read("rd_wrap", 4'd1, 32'h3000_0038, 8'd3, BURST_WRAP,
            32'h3000_0038, 32'h3000_003C,
            32'h3000_0030, 32'h3000_0034);

    err_beat = 2; err_resp = RESP_SLVERR;
    do_write("wr_slverr", 4'd5, 32'h5000_0000, 8'd3, BURST_INCR,
             32'hA000_0000, RESP_SLVERR,
             32'h5000_0000, 32'h5000_0004,
             32'h5000_0008, 32'h5000_000C);

    err_beat = 0; err_resp = RESP_DECERR;
    do_write("wr_decerr", 4'd2, 32'h5000_0040, 8'd1, BURST_INCR,
             32'hB000_0000, RESP_DECERR,
             32'h5000_0040, 32'h5000_0044, 0, 0);

    err_beat = -1;
    fork
      do_write("wr_fixed", 4'd6, 32'h4000_0010, 8'd1, BURST_FIXED,
               32'hC000_0000, RESP_OKAY,
               32'h4000_0010, 32'h4000_0010, 0, 0);
      do_read("rd_conc", 4'd9, 32'h2000_0100, 8'd3, BURST_INCR,
              32'h2000_0100, 32'h2000_0104,
              32'h2000_0108, 32'h2000_010C);
    join

    // Reset while waiting for a Lite B response mid-burst.
    b_hold = 1'b1;
    wb_idx = 0;
    slv_aw_id = 4'd7; slv_aw_addr = 32'h5000_0100;
    slv_aw_len = 8'd3; slv_aw_size = 3'd2;
    slv_aw_burst = BURST_INCR; slv_aw_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!slv_aw_ready && t < 50);
    @(posedge clk); #1;
    slv_aw_valid = 1'b0;
    slv_w_valid = 1'b1; slv_w_data = 32'h1234_5678;
    slv_w_strb = 4'hF;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!slv_w_ready && t < 50);
    chk("rst_w_taken", slv_w_ready, 1);
    @(posedge clk); #1;
    slv_w_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_wresp", mst_b_ready, 1);
    @(posedge clk); #1;
    areset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valids", {slv_aw_ready, slv_w_ready,
        slv_b_valid, mst_aw_valid, mst_w_valid,
        mst_b_ready}, 0);
    @(posedge clk); #1;
    areset = 1'b0;
    b_hold = 1'b0;
    slv_b_ready = 1'b1;
    saw_b = 1'b0;
    @(negedge clk);
    chk("rst_after_idle", slv_aw_ready, 1);
    chk("rst_after_bready", mst_b_ready, 0);
    repeat (5) begin
      @(negedge clk);
      saw_b = saw_b | slv_b_valid;
    end
    chk("rst_no_b", saw_b, 0);
    @(posedge clk); #1;
    slv_b_ready = 1'b0;

    do_write("wr_post_rst", 4'd8, 32'h5000_0200, 8'd0,
             BURST_INCR, 32'hD000_0000, RESP_OKAY,
             32'h5000_0200, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
